mux_scan_ctrl: RTL and testbench

- Sequential controller placed directly upstream of the 4-way, 4-bit gate-level data multiplexer.
- Round-robin arbitrates among four requesting sources and drives the multiplexer select.
- Samples the multiplexer output and presents the word, tagged with its channel, on a valid/ready output port.
- Closes the loop around the combinational mux, turning it into a fair, flow-controlled 4:1 funnel.

---
 rtl/mux_scan_ctrl_pkg.sv | 20 ++
 rtl/mux_scan_ctrl_if.sv | 33 +++
 rtl/mux_scan_ctrl_rr_pick.sv | 33 +++
 rtl/mux_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// rtl/mux_scan_ctrl_pkg.sv - shared types and constants for the mux scan controller
//
// Purpose: channel-count constants, FSM state encoding and the reset value
//          of the round-robin pointer, imported by every file of the block.
// Ports:   none (package).
package mux_scan_pkg;

  localparam int CH_W   = 2;
  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  // Pointer starts at the highest channel so channel 0 wins the first pick.
  localparam logic [CH_W-1:0] LAST_RST = 2'd3;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - bundle of mux select, grant and output stream signals
//
// Purpose: groups the request/mux side and the valid/ready output side.
// Ports:   req, mux_data, out_ready   - driven by the environment
//          sel, grant, out_data, out_chan, out_valid, drop - driven by controller
// Modports: master = controller, slave = sources/mux/consumer.
interface mux_scan_ctrl_if
  import mux_scan_pkg::*;
#(
  parameter int DATA_W = 4
) ();

  logic [NUM_CH-1:0] req;
  logic [DATA_W-1:0] mux_data;
  logic [CH_W-1:0]   sel;
  logic [NUM_CH-1:0] grant;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_chan;
  logic              out_valid;
  logic              out_ready;
  logic              drop;

  modport master (
    input  req, mux_data, out_ready,
    output sel, grant, out_data, out_chan, out_valid, drop
  );

  modport slave (
    output req, mux_data, out_ready,
    input  sel, grant, out_data, out_chan, out_valid, drop
  );

endinterface

// File: rtl/mux_scan_ctrl_rr_pick.sv
// rtl/mux_scan_ctrl_rr_pick.sv - combinational round-robin picker
//
// Purpose: returns the first requesting channel searching last+1, last+2, ...
//          modulo NUM_CH; the last-served channel itself is checked last.
// Ports:   i_req  - per-channel request bits
//          i_last - channel served most recently
//          o_pick - selected channel (meaningful only when o_any)
//          o_any  - at least one request present
module rr_pick
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_last,
  output logic [CH_W-1:0]   o_pick,
  output logic              o_any
);

  always_comb begin
    logic [CH_W-1:0] w_idx;
    o_pick = i_last;
    o_any  = 1'b0;
    w_idx  = i_last;
    for (int k = 1; k <= NUM_CH; k++) begin
      // Index arithmetic wraps naturally in CH_W bits; k == NUM_CH lands on i_last.
      w_idx = i_last + CH_W'(k);
      if (!o_any && i_req[w_idx]) begin
        o_pick = w_idx;
        o_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - round-robin select and capture controller around a 4:1 mux
//
// Purpose: arbitrates four sources, drives the mux select, samples the mux
//          output and offers it with its channel tag on a valid/ready port.
// Ports:   clk  - rising-edge clock
//          rst  - asynchronous active-high reset
//          bus  - mux_scan_ctrl_if.master (req, mux_data, sel, grant,
//                 out_data, out_chan, out_valid, out_ready, drop)
// Option:  MUX_SCAN_TIMEOUT_EN - drop a word left unaccepted for TIMEOUT
//          WAIT cycles; without it drop is tied low and WAIT holds forever.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  mux_scan_ctrl_if.master     bus
);

  state_t            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_sel, w_sel_nxt;
  logic [CH_W-1:0]   r_last, w_last_nxt;
  logic [DATA_W-1:0] r_out_data, w_data_nxt;
  logic [CH_W-1:0]   r_out_chan, w_chan_nxt;
  logic              r_out_valid, w_valid_nxt;
  logic [NUM_CH-1:0] w_grant;
  logic              w_drop;
  logic [CH_W-1:0]   w_pick;
  logic              w_any;
  logic              w_hs;

  // One picker serves both arbitration points: IDLE and accepted WAIT both
  // search from r_last, which SAMPLE has already updated.
  rr_pick u_rr_pick (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  assign w_hs = r_out_valid & bus.out_ready;

`ifdef MUX_SCAN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_last      <= LAST_RST;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
`ifdef MUX_SCAN_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_last      <= w_last_nxt;
      r_out_data  <= w_data_nxt;
      r_out_chan  <= w_chan_nxt;
      r_out_valid <= w_valid_nxt;
`ifdef MUX_SCAN_TIMEOUT_EN
      r_cnt       <= w_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_data_nxt  = r_out_data;
    w_chan_nxt  = r_out_chan;
    w_valid_nxt = r_out_valid;
    w_grant     = '0;
    w_drop      = 1'b0;
`ifdef MUX_SCAN_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_sel_nxt   = w_pick;
          w_state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        // sel has been stable for a full cycle, so mux_data is settled here.
        w_grant[r_sel] = 1'b1;
        w_data_nxt     = bus.mux_data;
        w_chan_nxt     = r_sel;
        w_valid_nxt    = 1'b1;
        w_last_nxt     = r_sel;
        w_state_nxt    = ST_WAIT;
`ifdef MUX_SCAN_TIMEOUT_EN
        w_cnt_nxt      = '0;
`endif
      end
      ST_WAIT: begin
        if (w_hs) begin
          w_valid_nxt = 1'b0;
          if (w_any) begin
            w_sel_nxt   = w_pick;
            w_state_nxt = ST_SAMPLE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
`ifdef MUX_SCAN_TIMEOUT_EN
        // A handshake on the final cycle takes priority over the drop.
        else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_drop      = 1'b1;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.sel       = r_sel;
  assign bus.grant     = w_grant;
  assign bus.out_data  = r_out_data;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_valid = r_out_valid;
  assign bus.drop      = w_drop;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed self-checking bench for mux_scan_ctrl
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] mux_in [4];
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  mux_scan_ctrl_if #(.DATA_W(4)) bus ();

  mux_scan_ctrl #(.DATA_W(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mux_data = mux_in[bus.sel];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.req       = 4'b0000;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) mux_in[i] = 4'h0;

    // Reset values
    do_reset();
    check("rst_sel",   8'(bus.sel),       8'h00);
    check("rst_grant", 8'(bus.grant),     8'h00);
    check("rst_valid", 8'(bus.out_valid), 8'h00);
    check("rst_data",  8'(bus.out_data),  8'h00);
    check("rst_chan",  8'(bus.out_chan),  8'h00);
    check("rst_drop",  8'(bus.drop),      8'h00);

    // out_ready high while nothing is valid: no effect
    bus.out_ready = 1'b1;
    tick();
    check("idle_ready_valid", 8'(bus.out_valid), 8'h00);
    check("idle_ready_grant", 8'(bus.grant),     8'h00);

    // Single transfer with 2-edge latency; req drops during SAMPLE
    mux_in[0] = 4'hA;
    bus.req   = 4'b0001;
    tick();
    check("t1_sel",   8'(bus.sel),       8'h00);
    check("t1_grant", 8'(bus.grant),     8'h01);
    check("t1_valid_early", 8'(bus.out_valid), 8'h00);
    bus.req = 4'b0000;
    tick();
    check("t1_valid", 8'(bus.out_valid), 8'h01);
    check("t1_data",  8'(bus.out_data),  8'h0A);
    check("t1_chan",  8'(bus.out_chan),  8'h00);
    check("t1_grant_wait", 8'(bus.grant), 8'h00);
    tick();
    check("t1_idle_valid", 8'(bus.out_valid), 8'h00);
    check("t1_idle_grant", 8'(bus.grant),     8'h00);

    // All four requesting from reset: 0,1,2,3,0 at one word per 2 cycles
    do_reset();
    for (int i = 0; i < 4; i++) mux_in[i] = 4'(i + 1);
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_grant", 8'(bus.grant), 8'(1 << (k % 4)));
      check("rr_valid_low", 8'(bus.out_valid), 8'h00);
      tick();
      check("rr_valid", 8'(bus.out_valid), 8'h01);
      check("rr_chan",  8'(bus.out_chan),  8'(k % 4));
      check("rr_data",  8'(bus.out_data),  8'((k % 4) + 1));
    end
    bus.req = 4'b0000;
    tick();
    check("rr_end_valid", 8'(bus.out_valid), 8'h00);

    // Only channel 2 requesting: re-picked every transfer
    bus.req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wrap_sel",   8'(bus.sel),   8'h02);
      check("wrap_grant", 8'(bus.grant), 8'h04);
      tick();
      check("wrap_chan", 8'(bus.out_chan), 8'h02);
      check("wrap_data", 8'(bus.out_data), 8'h03);
    end
    bus.req = 4'b0000;
    tick();

    // Consumer stalls 5 cycles, then accepts once
    bus.req       = 4'b0010;
    bus.out_ready = 1'b0;
    tick();
    check("stall_grant", 8'(bus.grant), 8'h02);
    bus.req = 4'b0000;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 8'(bus.out_valid), 8'h01);
      check("stall_chan",  8'(bus.out_chan),  8'h01);
      check("stall_data",  8'(bus.out_data),  8'h02);
      check("stall_grant_wait", 8'(bus.grant), 8'h00);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("stall_accept_valid", 8'(bus.out_valid), 8'h00);
    tick();
    check("stall_after_valid", 8'(bus.out_valid), 8'h00);
    check("stall_after_grant", 8'(bus.grant),     8'h00);

    // Reset asserted during SAMPLE: outputs clear at once, pointer restarts
    bus.req = 4'b1000;
    tick();
    check("rstmid_pre_grant", 8'(bus.grant), 8'h08);
    rst = 1'b1;
    #1;
    check("rstmid_grant", 8'(bus.grant),     8'h00);
    check("rstmid_valid", 8'(bus.out_valid), 8'h00);
    check("rstmid_sel",   8'(bus.sel),       8'h00);
    tick();
    rst     = 1'b0;
    bus.req = 4'b1111;
    tick();
    check("rstmid_sel_after",   8'(bus.sel),   8'h00);
    check("rstmid_grant_after", 8'(bus.grant), 8'h01);
    bus.req = 4'b0000;
    tick();
    tick();

    // Long stall: timeout drop when enabled, indefinite hold otherwise
    bus.req       = 4'b0001;
    bus.out_ready = 1'b0;
    tick();
    bus.req = 4'b0000;
    tick();
`ifdef MUX_SCAN_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      check("to_wait_drop", 8'(bus.drop), 8'h00);
      tick();
    end
    check("to_drop",       8'(bus.drop),      8'h01);
    check("to_valid_hold", 8'(bus.out_valid), 8'h01);
    tick();
    check("to_drop_end",  8'(bus.drop),      8'h00);
    check("to_valid_low", 8'(bus.out_valid), 8'h00);
    bus.req = 4'b0010;
    tick();
    check("to_idle_rearb", 8'(bus.grant), 8'h02);
`else
    for (int k = 0; k < 100; k++) begin
      check("hold_valid", 8'(bus.out_valid), 8'h01);
      check("hold_drop",  8'(bus.drop),      8'h00);
      tick();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
